// File: rtl/seq_detect_ctrl.sv
// Serial 4-bit pattern detector fed by parallel words. Each word is loaded and then scanned MSB first, one bit per cycle.
// Matches are counted per session, and a sticky irq is raised when the match count reaches a programmable threshold.
module seq_detect_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [3:0]        i_cfg_pattern,
  input  logic              i_cfg_overlap,
  input  logic [CNT_W-1:0]  i_cfg_thresh,
  input  logic [WORD_W-1:0] i_word_data,
  input  logic              i_word_valid,
  output logic              o_word_ready,
  output logic              o_busy,
  output logic              o_detect,
  output logic [CNT_W-1:0]  o_match_count,
  output logic              o_irq,
  input  logic              i_irq_clr
);

  localparam int BCW = $clog2(WORD_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

  typedef struct packed {
    logic [3:0]       pattern;
    logic             overlap;
    logic [CNT_W-1:0] thresh;
  } cfg_t;

  state_t            r_state, w_state_nxt;
  cfg_t              r_cfg;
  logic [WORD_W-1:0] r_shift;
  logic [BCW-1:0]    r_bitcnt;
  logic [2:0]        r_hist;
  logic [1:0]        r_fill;
  logic [CNT_W-1:0]  r_count;
  logic              r_detect;
  logic              r_irq;

  logic              w_ready, w_busy, w_cap, w_shift_en, w_sess_start;
  logic              w_bit, w_match, w_inc, w_irq_set;
  logic [CNT_W-1:0]  w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    w_cap        = 1'b0;
    w_shift_en   = 1'b0;
    w_sess_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (i_start) begin
          w_sess_start = 1'b1;
          w_state_nxt  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_ready = 1'b1;
        // stop wins over a word offered in the same cycle
        if (i_stop) w_state_nxt = S_IDLE;
        else if (i_word_valid) begin
          w_cap       = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_bitcnt == '0) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_bit     = r_shift[WORD_W-1];
  assign w_match   = w_shift_en && (r_fill == 2'd3) && ({r_hist, w_bit} == r_cfg.pattern);
  assign w_cnt_nxt = r_count + CNT_W'(1);
  assign w_inc     = w_match && !(&r_count);
  // Raised only on the increment that lands on the threshold, not while the count sits at or above it
  assign w_irq_set = w_inc && (r_cfg.thresh != '0) && (w_cnt_nxt == r_cfg.thresh);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cfg    <= '0;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_hist   <= '0;
      r_fill   <= '0;
      r_count  <= '0;
      r_detect <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_detect <= w_match;
      if (w_sess_start) begin
        r_cfg   <= '{pattern: i_cfg_pattern, overlap: i_cfg_overlap, thresh: i_cfg_thresh};
        r_count <= '0;
        r_hist  <= '0;
        r_fill  <= '0;
        r_irq   <= 1'b0;
      end else begin
        if (w_cap) begin
          r_shift  <= i_word_data;
          r_bitcnt <= BCW'(WORD_W - 1);
        end else if (w_shift_en) begin
          r_shift <= {r_shift[WORD_W-2:0], 1'b0};
          if (r_bitcnt != '0) r_bitcnt <= r_bitcnt - BCW'(1);
        end
        if (w_shift_en) begin
          // Non-overlapping mode: the bits of a match cannot contribute to the next match
          if (w_match && !r_cfg.overlap) begin
            r_hist <= '0;
            r_fill <= '0;
          end else begin
            r_hist <= {r_hist[1:0], w_bit};
            if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
          end
        end
        if (w_inc) r_count <= w_cnt_nxt;
        if (w_irq_set)      r_irq <= 1'b1;
        else if (i_irq_clr) r_irq <= 1'b0;
      end
    end
  end

  assign o_word_ready  = w_ready;
  assign o_busy        = w_busy;
  assign o_detect      = r_detect;
  assign o_match_count = r_count;
  assign o_irq         = r_irq;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl with WORD_W=8 and CNT_W=8.
// Inputs are driven and outputs are sampled on the falling clock edge.
module tb_seq_detect_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, stop, cfg_overlap, word_valid, irq_clr;
  logic [3:0] cfg_pattern;
  logic [7:0] cfg_thresh, word_data;
  logic       word_ready, busy, detect, irq;
  logic [7:0] match_count;
  logic [7:0] dm, im;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl #(.WORD_W(8), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_stop(stop),
    .i_cfg_pattern(cfg_pattern), .i_cfg_overlap(cfg_overlap), .i_cfg_thresh(cfg_thresh),
    .i_word_data(word_data), .i_word_valid(word_valid), .o_word_ready(word_ready),
    .o_busy(busy), .o_detect(detect), .o_match_count(match_count), .o_irq(irq),
    .i_irq_clr(irq_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_sess(input logic [3:0] pat, input logic ov, input logic [7:0] th);
    start = 1'b1; cfg_pattern = pat; cfg_overlap = ov; cfg_thresh = th;
    tick;
    start = 1'b0;
  endtask

  task automatic end_sess;
    stop = 1'b1;
    tick;
    stop = 1'b0;
  endtask

  // Offers one word in LOAD and returns the per-bit detect and irq masks (bit i = after time bit i)
  task automatic send_word(input logic [7:0] d, input int clr_at, input int stop_at,
                           output logic [7:0] dmask, output logic [7:0] imask);
    word_data = d; word_valid = 1'b1;
    tick;
    word_valid = 1'b0; word_data = ~d;
    for (int i = 0; i < 8; i++) begin
      irq_clr = (i == clr_at);
      if (i == stop_at) stop = 1'b1;
      tick;
      dmask[i] = detect;
      imask[i] = irq;
    end
    irq_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_overlap = 1'b0; word_valid = 1'b0;
    irq_clr = 1'b0; cfg_pattern = 4'h0; cfg_thresh = 8'h0; word_data = 8'h0;
    repeat (2) tick;
    chk("rst_busy", busy, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_detect", detect, 0);
    chk("rst_count", match_count, 0);
    chk("rst_irq", irq, 0);
    rst_n = 1'b1;
    tick;
    chk("idle_wait", busy, 0);

    // Overlapping 1011 over 1011_0110; cfg changed mid-session must be ignored
    start_sess(4'b1011, 1'b1, 8'd0);
    chk("load_busy", busy, 1);
    chk("load_ready", word_ready, 1);
    cfg_pattern = 4'b0000; cfg_overlap = 1'b0; cfg_thresh = 8'd1;
    send_word(8'b1011_0110, -1, -1, dm, im);
    chk("ov_mask", dm, 8'h48);
    chk("ov_count", match_count, 2);
    chk("ov_irq_cfg_ignored", irq, 0);
    chk("ov_ready_after", word_ready, 1);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("start_ignored_count", match_count, 2);
    chk("start_ignored_busy", busy, 1);
    end_sess;
    chk("end_busy", busy, 0);
    chk("end_count_hold", match_count, 2);

    // Non-overlapping, same word
    start_sess(4'b1011, 1'b0, 8'd0);
    chk("start_clears_count", match_count, 0);
    send_word(8'b1011_0110, -1, -1, dm, im);
    chk("nov_mask", dm, 8'h08);
    chk("nov_count", match_count, 1);
    end_sess;

    // 1001 spanning a word boundary
    start_sess(4'b1001, 1'b0, 8'd0);
    send_word(8'h01, -1, -1, dm, im);
    chk("span_w1_mask", dm, 8'h00);
    send_word(8'h20, -1, -1, dm, im);
    chk("span_w2_mask", dm, 8'h04);
    chk("span_count", match_count, 1);
    end_sess;

    // Threshold 3 with 8'hBB words (two matches per word)
    start_sess(4'b1011, 1'b1, 8'd3);
    send_word(8'hBB, -1, -1, dm, im);
    chk("th_w1_mask", dm, 8'h88);
    chk("th_w1_irq", im, 8'h00);
    send_word(8'hBB, -1, -1, dm, im);
    chk("th_w2_mask", dm, 8'h88);
    chk("th_w2_irq", im, 8'hF8);
    chk("th_w2_count", match_count, 4);
    irq_clr = 1'b1;
    tick;
    irq_clr = 1'b0;
    chk("irq_clr", irq, 0);
    send_word(8'hBB, -1, -1, dm, im);
    chk("irq_no_reset_past_th", im, 8'h00);
    chk("th_w3_count", match_count, 6);
    end_sess;
    start_sess(4'b1011, 1'b1, 8'd3);
    send_word(8'hBB, -1, -1, dm, im);
    send_word(8'hBB, 3, -1, dm, im);
    chk("set_beats_clr", im, 8'hF8);
    end_sess;
    chk("irq_hold_idle", irq, 1);
    chk("count_hold_idle", match_count, 4);
    start_sess(4'b1011, 1'b1, 8'd3);
    chk("start_clears_irq", irq, 0);
    end_sess;

    // stop during SHIFT of the 2nd word
    start_sess(4'b1011, 1'b1, 8'd0);
    send_word(8'b1011_0110, -1, -1, dm, im);
    send_word(8'b1011_0110, -1, 2, dm, im);
    chk("stop_word_done_mask", dm, 8'h48);
    chk("stop_word_done_ready", word_ready, 1);
    chk("stop_word_done_count", match_count, 4);
    tick;
    stop = 1'b0;
    chk("stop_idle_busy", busy, 0);
    chk("stop_idle_ready", word_ready, 0);

    // valid and stop together in LOAD
    start_sess(4'b1011, 1'b1, 8'd0);
    word_data = 8'b1011_0110; word_valid = 1'b1; stop = 1'b1;
    tick;
    word_valid = 1'b0; stop = 1'b0;
    chk("vs_busy", busy, 0);
    chk("vs_ready", word_ready, 0);
    repeat (9) tick;
    chk("vs_count", match_count, 0);

    // Asynchronous reset mid-word
    start_sess(4'b1011, 1'b1, 8'd1);
    send_word(8'b1011_0110, -1, -1, dm, im);
    chk("pre_rst_irq", irq, 1);
    word_data = 8'b1011_0110; word_valid = 1'b1;
    tick;
    word_valid = 1'b0;
    repeat (4) tick;
    chk("pre_rst_detect", detect, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_detect", detect, 0);
    chk("arst_busy", busy, 0);
    chk("arst_ready", word_ready, 0);
    chk("arst_count", match_count, 0);
    chk("arst_irq", irq, 0);
    tick;
    rst_n = 1'b1;
    repeat (2) tick;
    chk("post_rst_idle", busy, 0);
    start_sess(4'b1011, 1'b1, 8'd0);
    chk("resume_count0", match_count, 0);
    send_word(8'b1011_0110, -1, -1, dm, im);
    chk("resume_mask", dm, 8'h48);
    chk("resume_count", match_count, 2);
    end_sess;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
